// File: rtl/serial_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module   : serial_cmd_encoder
// Purpose  : Builds a serial command frame from up to MAX_CMD_PAYLOAD_BYTES
//            latched payload registers and pushes it byte by byte into a TX
//            FIFO. Frame: SOF SOF SPACE LEN payload[0..N-1] [CSUM] EOF EOF.
//            Transmit-side counterpart of serial_cmd_decoder.
// Ports    : clk                    system clock
//            rst                    asynchronous reset, active low
//            cmd_send               frame request, acted on at its rising edge
//            cmd_payload_len[7:0]   payload byte count N
//            cmd_payload_r0..r7     payload bytes, r0 sent first
//            cmd_sent_received      acknowledge, clears cmd_sent
//            fifo_full              TX FIFO backpressure
//            fifo_push              one-cycle push strobe
//            fifo_data[7:0]         byte presented with fifo_push
//            cmd_sent               frame finished (success or reject)
//            cmd_encode_success     valid while cmd_sent = 1
//            cmd_bytes_sent[7:0]    bytes pushed for the last frame
//            busy                   acceptance until cmd_sent rises
// Options  : define SERIAL_CMD_ENCODER_CHECKSUM_EN to insert a CSUM byte
//            (XOR of LEN and all payload bytes) between payload and EOF.
// Revision : 1.0  initial release
// ============================================================================
module serial_cmd_encoder #(
  parameter int unsigned MAX_CMD_PAYLOAD_BYTES = 8,
  parameter logic [7:0]  SOF_BYTE              = 8'hFF,
  parameter logic [7:0]  SPACE_BYTE            = 8'h00,
  parameter logic [7:0]  EOF_BYTE              = 8'hEE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_send,
  input  logic [7:0] cmd_payload_len,
  input  logic [7:0] cmd_payload_r0,
  input  logic [7:0] cmd_payload_r1,
  input  logic [7:0] cmd_payload_r2,
  input  logic [7:0] cmd_payload_r3,
  input  logic [7:0] cmd_payload_r4,
  input  logic [7:0] cmd_payload_r5,
  input  logic [7:0] cmd_payload_r6,
  input  logic [7:0] cmd_payload_r7,
  input  logic       cmd_sent_received,
  input  logic       fifo_full,
  output logic       fifo_push,
  output logic [7:0] fifo_data,
  output logic       cmd_sent,
  output logic       cmd_encode_success,
  output logic [7:0] cmd_bytes_sent,
  output logic       busy
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_CMD_PAYLOAD_BYTES);

`ifdef SERIAL_CMD_ENCODER_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_SOF1, S_SOF2, S_SPACE, S_LEN, S_PAYLOAD, S_CSUM, S_EOF1, S_EOF2, S_DONE
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_SOF1, S_SOF2, S_SPACE, S_LEN, S_PAYLOAD, S_EOF1, S_EOF2, S_DONE
  } state_t;
`endif

  state_t     state, state_n;
  logic       send_hist;
  logic [7:0] len_q, len_n;
  logic [7:0] pay_q [0:7];
  logic [7:0] pay_n [0:7];
  logic [2:0] idx, idx_n;
  logic       push_n;
  logic [7:0] data_n;
  logic       sent_n;
  logic       succ_n;
  logic [7:0] bytes_n;
  logic       busy_n;
`ifdef SERIAL_CMD_ENCODER_CHECKSUM_EN
  logic [7:0] csum, csum_n;
`endif

  // Emit-state helpers: which byte this state wants to push and where it
  // goes once the FIFO takes it.
  logic       emit_en;
  logic [7:0] emit_byte;
  state_t     adv_state;
  logic       send_rise;
  logic       len_bad;
  logic       last_payload;

  assign send_rise    = cmd_send & ~send_hist;
  assign len_bad      = (cmd_payload_len == 8'd0) || (cmd_payload_len > MAX_LEN);
  assign last_payload = ({5'd0, idx} == (len_q - 8'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= S_IDLE;
      send_hist          <= 1'b0;
      len_q              <= 8'd0;
      pay_q              <= '{default: 8'h00};
      idx                <= 3'd0;
      fifo_push          <= 1'b0;
      fifo_data          <= 8'h00;
      cmd_sent           <= 1'b0;
      cmd_encode_success <= 1'b0;
      cmd_bytes_sent     <= 8'd0;
      busy               <= 1'b0;
`ifdef SERIAL_CMD_ENCODER_CHECKSUM_EN
      csum               <= 8'h00;
`endif
    end else begin
      state              <= state_n;
      send_hist          <= cmd_send;
      len_q              <= len_n;
      pay_q              <= pay_n;
      idx                <= idx_n;
      fifo_push          <= push_n;
      fifo_data          <= data_n;
      cmd_sent           <= sent_n;
      cmd_encode_success <= succ_n;
      cmd_bytes_sent     <= bytes_n;
      busy               <= busy_n;
`ifdef SERIAL_CMD_ENCODER_CHECKSUM_EN
      csum               <= csum_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    len_n     = len_q;
    pay_n     = pay_q;
    idx_n     = idx;
    push_n    = 1'b0;
    data_n    = fifo_data;
    sent_n    = cmd_sent;
    succ_n    = cmd_encode_success;
    bytes_n   = cmd_bytes_sent;
    busy_n    = busy;
    emit_en   = 1'b0;
    emit_byte = 8'h00;
    adv_state = state;
`ifdef SERIAL_CMD_ENCODER_CHECKSUM_EN
    csum_n    = csum;
`endif

    case (state)
      S_IDLE: begin
        if (send_rise && !cmd_sent) begin
          len_n    = cmd_payload_len;
          pay_n[0] = cmd_payload_r0;
          pay_n[1] = cmd_payload_r1;
          pay_n[2] = cmd_payload_r2;
          pay_n[3] = cmd_payload_r3;
          pay_n[4] = cmd_payload_r4;
          pay_n[5] = cmd_payload_r5;
          pay_n[6] = cmd_payload_r6;
          pay_n[7] = cmd_payload_r7;
          idx_n    = 3'd0;
          busy_n   = 1'b1;
          bytes_n  = 8'd0;
`ifdef SERIAL_CMD_ENCODER_CHECKSUM_EN
          csum_n   = cmd_payload_len;
`endif
          state_n  = len_bad ? S_DONE : S_SOF1;
        end
      end
      S_SOF1: begin
        emit_en   = 1'b1;
        emit_byte = SOF_BYTE;
        adv_state = S_SOF2;
      end
      S_SOF2: begin
        emit_en   = 1'b1;
        emit_byte = SOF_BYTE;
        adv_state = S_SPACE;
      end
      S_SPACE: begin
        emit_en   = 1'b1;
        emit_byte = SPACE_BYTE;
        adv_state = S_LEN;
      end
      S_LEN: begin
        emit_en   = 1'b1;
        emit_byte = len_q;
        adv_state = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        emit_en   = 1'b1;
        emit_byte = pay_q[idx];
`ifdef SERIAL_CMD_ENCODER_CHECKSUM_EN
        adv_state = last_payload ? S_CSUM : S_PAYLOAD;
`else
        adv_state = last_payload ? S_EOF1 : S_PAYLOAD;
`endif
      end
`ifdef SERIAL_CMD_ENCODER_CHECKSUM_EN
      S_CSUM: begin
        emit_en   = 1'b1;
        emit_byte = csum;
        adv_state = S_EOF1;
      end
`endif
      S_EOF1: begin
        emit_en   = 1'b1;
        emit_byte = EOF_BYTE;
        adv_state = S_EOF2;
      end
      S_EOF2: begin
        emit_en   = 1'b1;
        emit_byte = EOF_BYTE;
        adv_state = S_DONE;
      end
      S_DONE: begin
        if (!cmd_sent) begin
          // A rejected frame never pushes anything, so a non-zero byte
          // count is exactly the "valid frame" condition.
          sent_n = 1'b1;
          busy_n = 1'b0;
          succ_n = (cmd_bytes_sent != 8'd0);
        end else if (cmd_sent_received) begin
          sent_n  = 1'b0;
          succ_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Common emit rule: push only when the FIFO has room, otherwise hold
    // both the state and the last presented byte.
    if (emit_en && !fifo_full) begin
      push_n  = 1'b1;
      data_n  = emit_byte;
      bytes_n = cmd_bytes_sent + 8'd1;
      state_n = adv_state;
      if (state == S_PAYLOAD) begin
        idx_n = idx + 3'd1;
`ifdef SERIAL_CMD_ENCODER_CHECKSUM_EN
        csum_n = csum ^ pay_q[idx];
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_cmd_encoder
// Purpose  : Self-checking bench for serial_cmd_encoder. A table of frames
//            plus randomized frames are compared against a frame-level
//            reference model; reset mid-frame is exercised by hand.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_cmd_encoder;

`ifdef SERIAL_CMD_ENCODER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_send = 1'b0;
  logic [7:0] cmd_payload_len = 8'd0;
  logic [7:0] pr [8];
  logic       cmd_sent_received = 1'b0;
  logic       fifo_full = 1'b0;
  logic       fifo_push;
  logic [7:0] fifo_data;
  logic       cmd_sent;
  logic       cmd_encode_success;
  logic [7:0] cmd_bytes_sent;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_cmd_encoder dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_send          (cmd_send),
    .cmd_payload_len   (cmd_payload_len),
    .cmd_payload_r0    (pr[0]),
    .cmd_payload_r1    (pr[1]),
    .cmd_payload_r2    (pr[2]),
    .cmd_payload_r3    (pr[3]),
    .cmd_payload_r4    (pr[4]),
    .cmd_payload_r5    (pr[5]),
    .cmd_payload_r6    (pr[6]),
    .cmd_payload_r7    (pr[7]),
    .cmd_sent_received (cmd_sent_received),
    .fifo_full         (fifo_full),
    .fifo_push         (fifo_push),
    .fifo_data         (fifo_data),
    .cmd_sent          (cmd_sent),
    .cmd_encode_success(cmd_encode_success),
    .cmd_bytes_sent    (cmd_bytes_sent),
    .busy              (busy)
  );

  // FIFO side: capture every pushed byte; a push must never follow a cycle
  // in which the FIFO reported full.
  logic [7:0] cap [$];
  logic       last_full = 1'b0;
  always @(negedge clk) begin
    if (fifo_push) begin
      checks++;
      if (last_full) begin
        errors++;
        $display("FAIL push_while_full: got push=1 data=%02h, required no push", fifo_data);
      end
      cap.push_back(fifo_data);
    end
    last_full = fifo_full;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: the expected byte stream of one frame.
  logic [7:0] exp_q [$];
  function automatic void model_frame(input int len, input logic [63:0] pl);
    logic [7:0] x;
    exp_q.delete();
    if (len < 1 || len > 8) return;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'(len));
    x = 8'(len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pl[8*i +: 8]);
      x = x ^ pl[8*i +: 8];
    end
    if (CS == 1) exp_q.push_back(x);
    exp_q.push_back(8'hEE);
    exp_q.push_back(8'hEE);
  endfunction

  // mode: 0 no backpressure, 1 random fifo_full, 2 five-cycle full window
  // in mid-payload. extra: pulse cmd_send again while busy.
  task automatic run_frame(input string tag, input int len, input logic [63:0] pl,
                           input int mode, input bit extra, input bit exp_succ,
                           input int exp_bytes);
    int cyc;
    int n;
    model_frame(len, pl);
    cap.delete();
    @(posedge clk); #1;
    cmd_payload_len = 8'(len);
    for (int i = 0; i < 8; i++) pr[i] = pl[8*i +: 8];
    cmd_send = 1'b1;
    @(posedge clk); #1;
    cmd_send = 1'b0;
    // Inputs are latched at acceptance; scramble them to prove it.
    cmd_payload_len = 8'($urandom);
    for (int i = 0; i < 8; i++) pr[i] = 8'($urandom);
    check({tag, " busy_after_accept"}, busy, 1);
    check({tag, " bytes_cleared"}, cmd_bytes_sent, 0);
    cyc = 0;
    while (!cmd_sent && cyc < 300) begin
      case (mode)
        1:       fifo_full = ($urandom_range(0, 2) == 0);
        2:       fifo_full = (cyc >= 6 && cyc < 11);
        default: fifo_full = 1'b0;
      endcase
      if (extra && cyc == 2) cmd_send = 1'b1;
      if (extra && cyc == 4) cmd_send = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    fifo_full = 1'b0;
    cmd_send  = 1'b0;
    check({tag, " cmd_sent"}, cmd_sent, 1);
    if (mode == 0) check({tag, " latency"}, cyc, exp_succ ? len + 7 + CS : 1);
    check({tag, " success"}, cmd_encode_success, exp_succ);
    check({tag, " bytes_sent"}, cmd_bytes_sent, exp_bytes);
    check({tag, " busy_done"}, busy, 0);
    check({tag, " push_count"}, cap.size(), exp_q.size());
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s byte%0d", tag, i), cap[i], exp_q[i]);
    // A rise while cmd_sent is held must be ignored.
    cmd_send = 1'b1;
    @(posedge clk); #1;
    cmd_send = 1'b0;
    check({tag, " sent_held"}, cmd_sent, 1);
    cmd_sent_received = 1'b1;
    @(posedge clk); #1;
    cmd_sent_received = 1'b0;
    check({tag, " sent_cleared"}, cmd_sent, 0);
    check({tag, " success_cleared"}, cmd_encode_success, 0);
    check({tag, " bytes_held"}, cmd_bytes_sent, exp_bytes);
    repeat (3) begin @(posedge clk); #1; end
    check({tag, " no_extra_frame"}, cap.size(), exp_q.size());
    check({tag, " idle_busy"}, busy, 0);
  endtask

  typedef struct packed {
    int          len;
    logic [63:0] pl;
    int          mode;
    bit          extra;
    bit          succ;
    int          bytes;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int len;
    logic [63:0] pl;
    int wcyc;

    vecs[0] = '{6,   64'h0000_6655_4433_2211, 0, 1'b0, 1'b1, 12 + CS};
    vecs[1] = '{8,   64'h8877_6655_4433_2211, 2, 1'b1, 1'b1, 14 + CS};
    vecs[2] = '{0,   64'h1234_5678_9ABC_DEF0, 0, 1'b0, 1'b0, 0};
    vecs[3] = '{9,   64'h1234_5678_9ABC_DEF0, 0, 1'b0, 1'b0, 0};
    vecs[4] = '{2,   64'h0000_0000_0000_0FA5, 0, 1'b0, 1'b1, 8 + CS};
    vecs[5] = '{1,   64'h0000_0000_0000_00C3, 1, 1'b0, 1'b1, 7 + CS};
    vecs[6] = '{8,   64'hFFEE_0011_DEAD_BEEF, 0, 1'b1, 1'b1, 14 + CS};
    vecs[7] = '{255, 64'h0102_0304_0506_0708, 0, 1'b0, 1'b0, 0};
    vecs[8] = '{6,   64'h0000_6050_4030_2010, 1, 1'b0, 1'b1, 12 + CS};

    for (int i = 0; i < 8; i++) pr[i] = 8'h00;

    // Reset state
    #2;
    check("reset push", fifo_push, 0);
    check("reset sent", cmd_sent, 0);
    check("reset busy", busy, 0);
    check("reset bytes", cmd_bytes_sent, 0);
    check("reset data", fifo_data, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int v = 0; v < 9; v++)
      run_frame($sformatf("vec%0d", v), vecs[v].len, vecs[v].pl, vecs[v].mode,
                vecs[v].extra, vecs[v].succ, vecs[v].bytes);

    // Reset asserted after three bytes have been pushed.
    cap.delete();
    @(posedge clk); #1;
    cmd_payload_len = 8'd8;
    for (int i = 0; i < 8; i++) pr[i] = 8'(i + 1);
    cmd_send = 1'b1;
    @(posedge clk); #1;
    cmd_send = 1'b0;
    wcyc = 0;
    while (cap.size() < 3 && wcyc < 50) begin
      @(posedge clk); #1;
      wcyc++;
    end
    check("rst mid_frame reached", (cap.size() >= 3), 1);
    rst = 1'b0;
    #1;
    check("rst async push", fifo_push, 0);
    check("rst async busy", busy, 0);
    check("rst async bytes", cmd_bytes_sent, 0);
    check("rst async data", fifo_data, 0);
    check("rst async sent", cmd_sent, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    run_frame("after_rst", 1, 64'h0000_0000_0000_005A, 0, 1'b0, 1'b1, 7 + CS);

    // Randomized frames against the model.
    for (int r = 0; r < 30; r++) begin
      len = $urandom_range(0, 10);
      pl  = {$urandom, $urandom};
      run_frame($sformatf("rnd%0d", r), len, pl, $urandom_range(0, 1), 1'b0,
                (len >= 1 && len <= 8),
                (len >= 1 && len <= 8) ? len + 6 + CS : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_cmd_encoder.md
Name: serial_cmd_encoder

Overview:
- Builds a serial command frame from up to MAX_CMD_PAYLOAD_BYTES parallel payload registers.
- Pushes the frame byte by byte into the TX FIFO (lib/fifo), from which the UART transmitter drains it.
- It is the transmit-side counterpart of serial_cmd_decoder.
- Frame format: SOF 0xFF, 0xFF; SPACE 0x00; PAYLOAD_LEN N; N payload bytes; EOF 0xEE, 0xEE.

Parameters:
- MAX_CMD_PAYLOAD_BYTES, 8: maximum N accepted; the design supports 1..8.
- SOF_BYTE, 8'hFF: start-of-frame byte, sent twice.
- SPACE_BYTE, 8'h00: separator byte.
- EOF_BYTE, 8'hEE: end-of-frame byte, sent twice.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-low reset.
- cmd_send  in  1  request to send a frame; acted on at its rising edge.
- cmd_payload_len  in  8  payload byte count N.
- cmd_payload_r0..cmd_payload_r7  in  8 each  payload bytes; r0 is sent first.
- cmd_sent_received  in  1  acknowledge; clears cmd_sent.
- fifo_full  in  1  TX FIFO backpressure.
- fifo_push  out  1  one-cycle push strobe to the FIFO.
- fifo_data  out  8  byte presented with fifo_push.
- cmd_sent  out  1  frame finished (success or reject); held until acknowledged.
- cmd_encode_success  out  1  valid only while cmd_sent=1.
- cmd_bytes_sent  out  8  number of bytes pushed for the last frame.
- busy  out  1  high from acceptance until cmd_sent rises.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0 immediately and the state goes to IDLE.
  - Any partial frame is abandoned. FIFO contents are not touched by this block.
- cmd_send edge detect: a one-flop history register; a rise is cmd_send=1 while the history bit is 0. Reset clears the history bit.
- Acceptance:
  - Occurs in IDLE on a cmd_send rise, with cmd_sent=0.
  - On that clock edge the block latches N and r0..r7, sets busy=1, and clears cmd_bytes_sent.
  - Payload inputs may change freely after acceptance.
- Length check at acceptance:
  - If N=0 or N>MAX_CMD_PAYLOAD_BYTES, go straight to DONE.
  - In that case cmd_encode_success=0, cmd_bytes_sent=0, and nothing is pushed.
- States: IDLE, SOF1, SOF2, SPACE, LEN, PAYLOAD, EOF1, EOF2, DONE.
- Emit rule, applied in every state from SOF1 to EOF2:
  - If fifo_full=0: register fifo_push=1 and fifo_data=byte, increment cmd_bytes_sent, and advance.
  - If fifo_full=1: fifo_push=0, fifo_data holds, state holds.
  - fifo_push is never high for a byte that was pushed on a previous cycle.
- PAYLOAD uses a 3-bit index starting at 0. It emits reg[index] and leaves for EOF1 after index N-1 is sent.
- Latency with no backpressure:
  - First push occurs 1 cycle after acceptance.
  - Pushes then follow on consecutive cycles: N+6 bytes in N+6 cycles.
  - cmd_sent rises 1 cycle after the last push.
- DONE:
  - Sets cmd_sent=1 and busy=0; cmd_encode_success=1 for a valid frame.
  - Holds until cmd_sent_received=1, then clears cmd_sent and cmd_encode_success on the next edge and returns to IDLE.
  - cmd_bytes_sent holds its value until the next acceptance.
- A cmd_send rise while busy or while cmd_sent=1 is ignored and is not queued.
- cmd_sent_received while not in DONE has no effect.
- cmd_bytes_sent = N+6 for a valid frame and never wraps for N≤8.

Optional Feature:
- Macro: SERIAL_CMD_ENCODER_CHECKSUM_EN.
- When defined:
  - A CSUM state sits between PAYLOAD and EOF1 and emits the XOR of the PAYLOAD_LEN byte and all N payload bytes.
  - The frame grows by one byte, so cmd_bytes_sent = N+7.
  - CSUM obeys the same backpressure rule as every other emit state.
- When undefined: the CSUM state and the XOR accumulator are absent, and the frame is exactly as specified above.

Test Plan:
- N=6, r0..r5=11,22,33,44,55,66, no backpressure, cmd_send pulse:
  - FIFO pops FF FF 00 06 11 22 33 44 55 66 EE EE.
  - cmd_sent=1, cmd_encode_success=1, cmd_bytes_sent=12.
  - cmd_sent_received clears cmd_sent.
- Loopback: encoder FIFO feeds serial_cmd_decoder, N=6, payload 10,20,30,40,50,60:
  - Decoder reports cmd_decode_success=1 with r0..r5 = 10..60.
- fifo_full=1 for 5 cycles in the middle of the payload, N=8:
  - No push occurs while fifo_full=1, with no byte lost or duplicated.
  - 14 bytes arrive in order and cmd_bytes_sent=14.
- N=0, then N=9:
  - Each gives cmd_sent=1, cmd_encode_success=0, and no fifo_push.
  - The FIFO stays empty.
- rst=0 asserted after 3 bytes pushed:
  - Outputs drop to 0 at once.
  - After release, a new N=1 frame sends 7 bytes correctly.
- Checksum build with N=2, payload A5,0F:
  - Frame is FF FF 00 02 A5 0F A8 EE EE, where A8 = 02^A5^0F.
  - cmd_bytes_sent=9.
